// File: rtl/alu_seq_pkg.sv
// alu_seq shared definitions: opcodes, flag bit positions, FSM states.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_SBC  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  localparam int FLG_V = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_Z = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_adder.sv
// prefix_adder_n: Kogge-Stone WIDTH-bit adder with carry-in/out,
// shared by all add/subtract/compare opcodes of alu_seq.
module prefix_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co
);

  localparam int LVL = $clog2(WIDTH);

  logic [WIDTH-1:0] w_p0;
  logic [WIDTH:0]   w_c;

  assign w_p0 = i_a ^ i_b;

  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    if (l == 0) begin : g_init
      assign w_g = i_a & i_b;
      assign w_p = w_p0;
    end else begin : g_comb
      localparam int D = 1 << (l - 1);
      // low D bits already span to bit 0 and pass through
      assign w_g = g_lvl[l-1].w_g |
                   (g_lvl[l-1].w_p & (g_lvl[l-1].w_g << D));
      assign w_p = g_lvl[l-1].w_p &
                   ~(~g_lvl[l-1].w_p << D);
    end
  end

  assign w_c = {g_lvl[LVL].w_g |
                (g_lvl[LVL].w_p & {WIDTH{i_ci}}), i_ci};
  assign o_s  = w_p0 ^ w_c[WIDTH-1:0];
  assign o_co = w_c[WIDTH];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered handshaked ALU with persistent Z/C/N/V flags.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_err;

  logic             w_acc;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_bop;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_cin;
  logic             w_co;
  logic             w_ovf;
  logic             w_c;
  logic             w_v;
  logic             w_err;

  assign in_ready = !rst && (r_state == ST_IDLE ||
                    (r_state == ST_DONE && out_ready));
  assign w_acc     = in_valid && in_ready;
  assign w_sh      = b[SHW-1:0];
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign flags     = r_flags;
  assign err       = r_err;

  // subtract-style by default: SUB, SLT, SLTU all need A+~B+1
  always_comb begin
    w_bop = ~b;
    w_cin = 1'b1;
    unique case (1'b1)
      (op == OP_ADD): begin
        w_bop = b;
        w_cin = 1'b0;
      end
      (op == OP_ADC): begin
        w_bop = b;
        w_cin = r_flags[FLG_C];
      end
      (op == OP_SBC): w_cin = r_flags[FLG_C];
      default: ;
    endcase
  end

  prefix_adder_n #(.WIDTH(WIDTH)) u_add (
    .i_a  (a),
    .i_b  (w_bop),
    .i_ci (w_cin),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  assign w_ovf = (a[WIDTH-1] == w_bop[WIDTH-1]) &&
                 (w_sum[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU_SEQ_MUL_EN
  logic                 w_mul;
  logic [WIDTH-1:0]     r_result_hi;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_prod;
  logic [SHW-1:0]       r_cnt;
  logic [WIDTH:0]       w_psum;
  logic [2*WIDTH-1:0]   w_pnx;

  // high half accumulates, low half shifts the multiplier out
  assign w_psum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                  {1'b0, r_mcand & {WIDTH{r_prod[0]}}};
  assign w_pnx     = {w_psum, r_prod[WIDTH-1:1]};
  assign result_hi = r_result_hi;
`else
  assign result_hi = '0;
`endif

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_mul = 1'b0;
`endif
    unique case (1'b1)
      (op == OP_ADD), (op == OP_SUB),
      (op == OP_ADC), (op == OP_SBC): begin
        w_res = w_sum;
        w_c   = w_co;
        w_v   = w_ovf;
      end
      (op == OP_AND): w_res = a & b;
      (op == OP_OR):  w_res = a | b;
      (op == OP_XOR): w_res = a ^ b;
      (op == OP_SHL): w_res = a << w_sh;
      (op == OP_SHR): w_res = a >> w_sh;
      (op == OP_SRA): w_res = $signed(a) >>> w_sh;
      (op == OP_SLTU):
        w_res = {{(WIDTH-1){1'b0}}, !w_co};
      (op == OP_SLT):
        w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
`ifdef ALU_SEQ_MUL_EN
      (op == OP_MUL): w_mul = 1'b1;
`endif
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_flags  <= '0;
      r_err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_result_hi <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
`ifdef ALU_SEQ_MUL_EN
          if (w_acc && w_mul) begin
            r_state <= ST_BUSY;
            r_mcand <= a;
            r_prod  <= {{WIDTH{1'b0}}, b};
            r_cnt   <= '0;
          end else
`endif
          if (w_acc) begin
            r_state  <= ST_DONE;
            r_result <= w_res;
            r_err    <= w_err;
`ifdef ALU_SEQ_MUL_EN
            r_result_hi <= '0;
`endif
            if (!w_err)
              r_flags <= {w_res == '0, w_c,
                          w_res[WIDTH-1], w_v};
          end else if (r_state == ST_DONE && out_ready) begin
            r_state <= ST_IDLE;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        ST_BUSY: begin
          r_prod <= w_pnx;
          r_cnt  <= r_cnt + SHW'(1);
          if (r_cnt == SHW'(WIDTH - 1)) begin
            r_state     <= ST_DONE;
            r_result    <= w_pnx[WIDTH-1:0];
            r_result_hi <= w_pnx[2*WIDTH-1:WIDTH];
            r_err       <= 1'b0;
            r_flags     <= {w_pnx[WIDTH-1:0] == '0, 1'b0,
                            w_pnx[WIDTH-1], 1'b0};
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=8)
// against an arithmetic reference model and a result scoreboard.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [3:0] op = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic [3:0] flags;
  logic       err;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] m_flags = '0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] rh;
    logic [3:0] f;
    logic       e;
  } exp_t;

  exp_t q[$];

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic ref_op(input logic [3:0] o,
                        input logic [7:0] x, y,
                        output exp_t e);
    int ua, ub, sa, sb, t, st, sh;
    logic c, v, il;
    logic cin;
    logic [7:0] r, rh;
    ua = x; ub = y;
    sa = x[7] ? ua - 256 : ua;
    sb = y[7] ? ub - 256 : ub;
    sh = ub % 8;
    cin = m_flags[2];
    c = 0; v = 0; il = 0; r = 0; rh = 0;
    t = 0; st = 0;
    case (o)
      4'd0: begin t = ua + ub; st = sa + sb; end
      4'd1: begin t = ua + 255 - ub + 1; st = sa - sb; end
      4'd8: begin t = ua + ub + cin; st = sa + sb + cin; end
      4'd9: begin t = ua + 255 - ub + cin; st = sa - sb - 1 + cin; end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: begin t = ua << sh; r = t[7:0]; end
      4'd6: r = 8'(ua >> sh);
      4'd10: begin st = sa >>> sh; r = st[7:0]; end
      4'd7: r = (ua < ub) ? 8'd1 : 8'd0;
      4'd11: r = (sa < sb) ? 8'd1 : 8'd0;
`ifdef ALU_SEQ_MUL_EN
      4'd12: begin t = ua * ub; r = t[7:0]; rh = t[15:8]; end
`endif
      default: il = 1;
    endcase
    if (o == 4'd0 || o == 4'd1 || o == 4'd8 || o == 4'd9) begin
      r = t[7:0];
      c = (t > 255);
      v = (st > 127) || (st < -128);
    end
    if (!il) m_flags = {r == 8'd0, c, r[7], v};
    e.r = r; e.rh = rh; e.f = m_flags; e.e = il;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic beat(input logic [3:0] o, input logic [7:0] x, y);
    op = o; a = x; b = y; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs got v=%b r=%b want 0 0", out_valid, in_ready);
    end
    n_vec++;
    if ({result, result_hi, flags, err} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_regs got %h %h %h %b want 0",
               result, result_hi, flags, err);
    end
    rst = 0; #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release in_ready got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL add_pre out_valid got %b want 0", out_valid);
    end
    beat(4'd0, 8'hFF, 8'h01);
    n_vec++;
    if ({out_valid, result, flags, err} !== {1'b1, 8'h00, 4'b1100, 1'b0}) begin
      n_err++;
      $display("FAIL add v=%b res=%h fl=%b err=%b want 1 00 1100 0",
               out_valid, result, flags, err);
    end
    @(negedge clk);
  endtask

  task automatic test_sub_adc();
    op = 4'd1; a = 8'h80; b = 8'h01; in_valid = 1;
    @(negedge clk);
    n_vec++;
    if ({out_valid, result, flags} !== {1'b1, 8'h7F, 4'b0101}) begin
      n_err++;
      $display("FAIL sub v=%b res=%h fl=%b want 1 7f 0101",
               out_valid, result, flags);
    end
    op = 4'd8; a = 8'h01; b = 8'h01;
    @(negedge clk);
    in_valid = 0;
    n_vec++;
    if ({out_valid, result, flags} !== {1'b1, 8'h03, 4'b0000}) begin
      n_err++;
      $display("FAIL adc_b2b v=%b res=%h fl=%b want 1 03 0000",
               out_valid, result, flags);
    end
    @(negedge clk);
  endtask

  task automatic test_cmp_shift();
    logic [3:0] ops [3];
    logic [7:0] xa [3];
    logic [7:0] xb [3];
    logic [7:0] xr [3];
    logic [3:0] xf [3];
    ops = '{4'd11, 4'd7, 4'd10};
    xa  = '{8'hFF, 8'hFF, 8'h90};
    xb  = '{8'h01, 8'h01, 8'h02};
    xr  = '{8'h01, 8'h00, 8'hE4};
    xf  = '{4'b0000, 4'b1000, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      op = ops[i]; a = xa[i]; b = xb[i]; in_valid = 1;
      @(negedge clk);
      n_vec++;
      if ({out_valid, result, flags} !== {1'b1, xr[i], xf[i]}) begin
        n_err++;
        $display("FAIL cmp_shift[%0d] v=%b res=%h fl=%b want 1 %h %b",
                 i, out_valid, result, flags, xr[i], xf[i]);
      end
    end
    in_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    beat(4'd12, 8'hFF, 8'hFF);
`ifdef ALU_SEQ_MUL_EN
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL mul_busy[%0d] v=%b rdy=%b want 0 0",
                 i, out_valid, in_ready);
      end
      @(negedge clk);
    end
    n_vec++;
    if ({out_valid, result, result_hi, flags, err} !==
        {1'b1, 8'h01, 8'hFE, 4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL mul v=%b lo=%h hi=%h fl=%b err=%b want 1 01 fe 0000 0",
               out_valid, result, result_hi, flags, err);
    end
`else
    n_vec++;
    if ({out_valid, result, result_hi, err} !==
        {1'b1, 8'h00, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL mul_off v=%b lo=%h hi=%h err=%b want 1 00 00 1",
               out_valid, result, result_hi, err);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    beat(4'd0, 8'h70, 8'h20);
    op = 4'd4; a = 8'hF0; b = 8'h0F; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if ({out_valid, result, flags, in_ready} !==
          {1'b1, 8'h90, 4'b0011, 1'b0}) begin
        n_err++;
        $display("FAIL stall[%0d] v=%b res=%h fl=%b rdy=%b want 1 90 0011 0",
                 i, out_valid, result, flags, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    n_vec++;
    if ({out_valid, result, flags} !== {1'b1, 8'hFF, 4'b0010}) begin
      n_err++;
      $display("FAIL stall_release v=%b res=%h fl=%b want 1 ff 0010",
               out_valid, result, flags);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    beat(4'd0, 8'hFF, 8'h01);
    @(negedge clk);
    beat(4'd12, 8'h03, 8'h05);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    n_vec++;
    if ({out_valid, in_ready, flags, result, result_hi, err} !== 23'd0) begin
      n_err++;
      $display("FAIL rst_mid_mul v=%b rdy=%b fl=%b res=%h hi=%h err=%b want 0",
               out_valid, in_ready, flags, result, result_hi, err);
    end
    rst = 0;
    repeat (10) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_discard out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    beat(4'd0, 8'hFF, 8'h01);
    @(negedge clk);
    beat(4'd14, 8'h55, 8'hAA);
    n_vec++;
    if ({out_valid, result, result_hi, flags, err} !==
        {1'b1, 8'h00, 8'h00, 4'b1100, 1'b1}) begin
      n_err++;
      $display("FAIL illegal v=%b res=%h hi=%h fl=%b err=%b want 1 00 00 1100 1",
               out_valid, result, result_hi, flags, err);
    end
    @(negedge clk);
    beat(4'd3, 8'h00, 8'h00);
    n_vec++;
    if ({result, flags, err} !== {8'h00, 4'b1000, 1'b0}) begin
      n_err++;
      $display("FAIL after_illegal res=%h fl=%b err=%b want 00 1000 0",
               result, flags, err);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t e;
    exp_t g;
    do_reset();
    m_flags = '0;
    q.delete();
    for (int cyc = 0; cyc < 440; cyc++) begin
      if (cyc < 400) begin
        out_ready = ($urandom % 4) != 0;
        in_valid  = ($urandom % 3) != 0;
      end else begin
        out_ready = 1; in_valid = 0;
      end
      op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
      #1;
      if (out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL rand_spurious res=%h want no result", result);
        end else begin
          e = q.pop_front();
          g = {result, result_hi, flags, err};
          if (g !== e) begin
            n_err++;
            $display("FAIL rand[%0d] got %h/%h/%b/%b want %h/%h/%b/%b",
                     cyc, g.r, g.rh, g.f, g.e, e.r, e.rh, e.f, e.e);
          end
        end
      end
      if (in_valid && in_ready) begin
        ref_op(op, a, b, e);
        q.push_back(e);
      end
      @(negedge clk);
    end
    n_vec++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rand_drain pending=%0d v=%b want 0 0",
               q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_adc();
    test_cmp_shift();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
